trojan_leak_rx: RTL

TROJAN_LEAK_RX -- requirements
Module: trojan_leak_rx

---
 rtl/trojan_leak_rx_if.sv | 23 ++
 rtl/trojan_leak_rx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/trojan_leak_rx_if.sv
// Bundle of the leak-symbol input stream and the reassembled-word output stream.
// master drives symbols and out_ready; slave is the receiver.
interface trojan_leak_rx_if;
   logic        sym_valid;
   logic [1:0]  sym;
   logic [3:0]  sel;
   logic        out_valid;
   logic [63:0] out_data;
   logic [1:0]  out_idx;
   logic        out_ready;
   logic [15:0] lanes_done;
   logic        frame_err;

   modport master (
      output sym_valid, sym, sel, out_ready,
      input  out_valid, out_data, out_idx, lanes_done, frame_err
   );

   modport slave (
      input  sym_valid, sym, sel, out_ready,
      output out_valid, out_data, out_idx, lanes_done, frame_err
   );
endinterface

// File: rtl/trojan_leak_rx.sv
// Reassembles 2-bit leak symbols into 16-bit lane words and drains four 64-bit words per record.
// Define TROJAN_LEAK_RX_TIMEOUT_EN to abort frames after 4 consecutive idle cycles in RECV.
module trojan_leak_rx (
   input  logic            clk,
   input  logic            rst_n,
   trojan_leak_rx_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RECV, STORE, DRAIN} state_t;

   state_t      state_reg, state_next;
   logic [15:0] word_reg, word_next;
   logic [2:0]  count_reg, count_next;
   logic [3:0]  lsel_reg, lsel_next;
   logic [1:0]  idx_reg, idx_next;
   logic [15:0] lanes_done_reg, lanes_done_next;
   logic [15:0] lanes_merged;
   logic [3:0][63:0] rows;
   logic        do_store;
   logic        drain_done;
`ifdef TROJAN_LEAK_RX_TIMEOUT_EN
   logic [1:0]  gap_reg, gap_next;
   logic        timeout_hit;
`endif

   assign do_store     = (state_reg == STORE);
   assign drain_done   = (state_reg == DRAIN) && bus.out_ready && (idx_reg == 2'd3);
   assign lanes_merged = lanes_done_reg | (16'd1 << lsel_reg);
`ifdef TROJAN_LEAK_RX_TIMEOUT_EN
   assign timeout_hit  = (state_reg == RECV) && !bus.sym_valid && (gap_reg == 2'd3);
`endif

   // State and control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         word_reg       <= '0;
         count_reg      <= '0;
         lsel_reg       <= '0;
         idx_reg        <= '0;
         lanes_done_reg <= '0;
`ifdef TROJAN_LEAK_RX_TIMEOUT_EN
         gap_reg        <= '0;
`endif
      end else begin
         state_reg      <= state_next;
         word_reg       <= word_next;
         count_reg      <= count_next;
         lsel_reg       <= lsel_next;
         idx_reg        <= idx_next;
         lanes_done_reg <= lanes_done_next;
`ifdef TROJAN_LEAK_RX_TIMEOUT_EN
         gap_reg        <= gap_next;
`endif
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_next      = state_reg;
      word_next       = word_reg;
      count_next      = count_reg;
      lsel_next       = lsel_reg;
      idx_next        = idx_reg;
      lanes_done_next = lanes_done_reg;
`ifdef TROJAN_LEAK_RX_TIMEOUT_EN
      gap_next        = gap_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (bus.sym_valid) begin
               word_next  = {bus.sym, 14'd0};
               lsel_next  = bus.sel;
               count_next = 3'd1;
               state_next = RECV;
`ifdef TROJAN_LEAK_RX_TIMEOUT_EN
               gap_next   = '0;
`endif
            end
         end
         RECV: begin
            if (bus.sym_valid) begin
               // Shift right so the first symbol ends at word[1:0] after eight symbols
               word_next  = {bus.sym, word_reg[15:2]};
               count_next = count_reg + 3'd1;
               if (count_reg == 3'd7)
                  state_next = STORE;
`ifdef TROJAN_LEAK_RX_TIMEOUT_EN
               gap_next   = '0;
            end else if (gap_reg == 2'd3) begin
               word_next  = '0;
               count_next = '0;
               gap_next   = '0;
               state_next = IDLE;
            end else begin
               gap_next   = gap_reg + 2'd1;
`endif
            end
         end
         STORE: begin
            lanes_done_next = lanes_merged;
            state_next      = (lanes_merged == 16'hFFFF) ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (bus.out_ready) begin
               if (idx_reg == 2'd3) begin
                  idx_next        = '0;
                  lanes_done_next = '0;
                  state_next      = IDLE;
               end else begin
                  idx_next = idx_reg + 2'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Each 64-bit entry k collects nibble k of every lane's word
   generate
      for (genvar gk = 0; gk < 4; gk++) begin : gen_row
         logic [63:0] row_reg, row_next;
         for (genvar gi = 0; gi < 16; gi++) begin : gen_lane
            assign row_next[4*gi +: 4] = (do_store && lsel_reg == 4'(gi)) ?
                                         word_reg[4*gk +: 4] : row_reg[4*gi +: 4];
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               row_reg <= '0;
            else if (drain_done)
               row_reg <= '0;
            else
               row_reg <= row_next;
         end
         assign rows[gk] = row_reg;
      end
   endgenerate

   // Outputs
   always_comb begin
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_idx   = '0;
      bus.frame_err = 1'b0;
      if (state_reg == DRAIN) begin
         bus.out_valid = 1'b1;
         bus.out_data  = rows[idx_reg];
         bus.out_idx   = idx_reg;
      end
      if (bus.sym_valid && (state_reg == STORE || state_reg == DRAIN))
         bus.frame_err = 1'b1;
`ifdef TROJAN_LEAK_RX_TIMEOUT_EN
      if (timeout_hit)
         bus.frame_err = 1'b1;
`endif
   end

   assign bus.lanes_done = lanes_done_reg;

endmodule
